// File: rtl/sobel_window_gen_pkg.sv
// Shared types and window indexing for the Sobel 3x3 window generator.
// Element (r,c) of a window lives at flat index 3r+c; r=0 is the oldest line.
package sobel_pkg;

    localparam int WIN_DIM = 3;

    localparam int TL = 0;
    localparam int TC = 1;
    localparam int TR = 2;
    localparam int ML = 3;
    localparam int MC = 4;
    localparam int MR = 5;
    localparam int BL = 6;
    localparam int BC = 7;
    localparam int BR = 8;

    typedef logic [7:0] pixel_t;

    function automatic int win_idx(input int r, input int c);
        return WIN_DIM * r + c;
    endfunction

endpackage

// File: rtl/sobel_window_gen_if.sv
// Pixel-in / window-out handshake bundle for sobel_window_gen.
// SOBEL_WINDOW_COORD_EN adds the window-centre coordinate outputs row_o/col_o.
interface sobel_window_gen_if #(
    parameter int WIDTH_P        = 8,
    parameter int LINE_WIDTH_P   = 640,
    parameter int FRAME_HEIGHT_P = 480
);
    logic [WIDTH_P-1:0]   data_i;
    logic                 valid_i;
    logic                 ready_o;
    logic [9*WIDTH_P-1:0] window_o;
    logic                 valid_o;
    logic                 ready_i;

`ifdef SOBEL_WINDOW_COORD_EN
    logic [$clog2(FRAME_HEIGHT_P)-1:0] row_o;
    logic [$clog2(LINE_WIDTH_P)-1:0]   col_o;

    modport slave (
        input  data_i, valid_i, ready_i,
        output ready_o, window_o, valid_o, row_o, col_o
    );
    modport master (
        output data_i, valid_i, ready_i,
        input  ready_o, window_o, valid_o, row_o, col_o
    );
`else
    modport slave (
        input  data_i, valid_i, ready_i,
        output ready_o, window_o, valid_o
    );
    modport master (
        output data_i, valid_i, ready_i,
        input  ready_o, window_o, valid_o
    );
`endif

endinterface

// File: rtl/sobel_window_gen_ram.sv
// sync_ram_block: single-port line RAM, 1-cycle registered read, read-before-write.
// Latency: rd_dat valid the cycle after rd_en; rd_dat holds while rd_en is low.
// Backpressure: none; the caller gates rd_en/wr_en.
module sync_ram_block #(
    parameter int  WIDTH_P = 8,
    parameter int  DEPTH_P = 640,
    localparam int AW      = $clog2(DEPTH_P)
) (
    input  logic               clk_i,
    input  logic               rst_n,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [AW-1:0]      addr,
    input  logic [WIDTH_P-1:0] wr_dat,
    output logic [WIDTH_P-1:0] rd_dat
);

    logic [WIDTH_P-1:0] mem [DEPTH_P];

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[addr] <= wr_dat;
        end
    end

    // Contents are never cleared; only the read register is reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            rd_dat <= '0;
        end else if (rd_en) begin
            rd_dat <= mem[addr];
        end
    end

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator; emits interior windows only. Optional SOBEL_WINDOW_COORD_EN.
// Latency: pixel accepted in cycle T completes its window with valid_o in T+2.
// Backpressure: ready_o drops while a window is held (valid_o && !ready_i); all state freezes.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int WIDTH_P        = 8,
    parameter int LINE_WIDTH_P   = 640,
    parameter int FRAME_HEIGHT_P = 480
) (
    input logic              clk_i,
    input logic              rst_i,
    sobel_window_gen_if.slave bus
);

    localparam int CW = $clog2(LINE_WIDTH_P);
    localparam int RW = $clog2(FRAME_HEIGHT_P);

    localparam logic [CW-1:0] COL_LAST = CW'(LINE_WIDTH_P - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_HEIGHT_P - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [CW-1:0]      col_q;
    logic [RW-1:0]      row_q;
    logic               sel_q;

    logic               s1_vld_q;
    logic [WIDTH_P-1:0] s1_pix_q;
    logic [RW-1:0]      s1_row_q;
    logic [CW-1:0]      s1_col_q;
    logic               s1_sel_q;

    logic [WIDTH_P-1:0] ram0_dat;
    logic [WIDTH_P-1:0] ram1_dat;
    logic [WIDTH_P-1:0] top_pix;
    logic [WIDTH_P-1:0] mid_pix;

    logic [WIDTH_P-1:0]   win_q [WIN_DIM*WIN_DIM];
    logic                 win_vld_q;
    logic [9*WIDTH_P-1:0] window_d;

    logic advance;
    logic accept;
    logic shift;
    logic line_end;

    assign advance     = !win_vld_q || bus.ready_i;
    assign bus.ready_o = !rst_i && advance;
    assign accept      = bus.valid_i && bus.ready_o;
    assign shift       = s1_vld_q && advance;
    assign line_end    = (col_q == COL_LAST);

    // sel=0: ram0 is prev1, ram1 is prev2. Only the prev2 RAM is written.
    sync_ram_block #(
        .WIDTH_P (WIDTH_P),
        .DEPTH_P (LINE_WIDTH_P)
    ) u_ram0 (
        .clk_i  (clk_i),
        .rst_n  (!rst_i),
        .rd_en  (accept),
        .wr_en  (accept && sel_q),
        .addr   (col_q),
        .wr_dat (bus.data_i),
        .rd_dat (ram0_dat)
    );

    sync_ram_block #(
        .WIDTH_P (WIDTH_P),
        .DEPTH_P (LINE_WIDTH_P)
    ) u_ram1 (
        .clk_i  (clk_i),
        .rst_n  (!rst_i),
        .rd_en  (accept),
        .wr_en  (accept && !sel_q),
        .addr   (col_q),
        .wr_dat (bus.data_i),
        .rd_dat (ram1_dat)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col_q <= '0;
            row_q <= '0;
            sel_q <= 1'b0;
        end else if (accept) begin
            sel_q <= sel_q ^ line_end;
            if (line_end) begin
                col_q <= '0;
                row_q <= (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
                col_q <= col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_vld_q <= 1'b0;
            s1_pix_q <= '0;
            s1_row_q <= '0;
            s1_col_q <= '0;
            s1_sel_q <= 1'b0;
        end else if (accept) begin
            s1_vld_q <= 1'b1;
            s1_pix_q <= bus.data_i;
            s1_row_q <= row_q;
            s1_col_q <= col_q;
            s1_sel_q <= sel_q;
        end else if (shift) begin
            s1_vld_q <= 1'b0;
        end
    end

    // sel may toggle on the same edge as the read, so role mapping uses the copy taken with s1.
    assign top_pix = s1_sel_q ? ram0_dat : ram1_dat;
    assign mid_pix = s1_sel_q ? ram1_dat : ram0_dat;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < WIN_DIM*WIN_DIM; i++) begin
                win_q[i] <= '0;
            end
            win_vld_q <= 1'b0;
        end else if (shift) begin
            win_q[TL] <= win_q[TC];
            win_q[TC] <= win_q[TR];
            win_q[TR] <= top_pix;
            win_q[ML] <= win_q[MC];
            win_q[MC] <= win_q[MR];
            win_q[MR] <= mid_pix;
            win_q[BL] <= win_q[BC];
            win_q[BC] <= win_q[BR];
            win_q[BR] <= s1_pix_q;
            win_vld_q <= (s1_row_q >= ROW_TWO) && (s1_col_q >= COL_TWO);
        end else if (bus.ready_i) begin
            win_vld_q <= 1'b0;
        end
    end

    always_comb begin
        window_d = '0;
        for (int r = 0; r < WIN_DIM; r++) begin
            for (int c = 0; c < WIN_DIM; c++) begin
                window_d[WIDTH_P*win_idx(r, c) +: WIDTH_P] = win_q[win_idx(r, c)];
            end
        end
    end

    assign bus.window_o = window_d;
    assign bus.valid_o  = win_vld_q;

`ifdef SOBEL_WINDOW_COORD_EN
    logic [RW-1:0] ctr_row_q;
    logic [CW-1:0] ctr_col_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctr_row_q <= '0;
            ctr_col_q <= '0;
        end else if (shift) begin
            ctr_row_q <= s1_row_q - RW'(1);
            ctr_col_q <= s1_col_q - CW'(1);
        end
    end

    assign bus.row_o = ctr_row_q;
    assign bus.col_o = ctr_col_q;
`endif

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen: 4x4 instance for directed scenarios, 6x5 instance for random gaps.
`timescale 1ns/1ps
module tb_sobel_window_gen;
    import sobel_pkg::*;

    localparam int AW_ = 4, AH = 4, BW = 6, BH = 5;

    typedef logic [71:0] win_t;
    typedef struct { win_t win; int row; int col; } exp_t;
    typedef pixel_t pix_q_t [$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    sobel_window_gen_if #(.WIDTH_P(8), .LINE_WIDTH_P(AW_), .FRAME_HEIGHT_P(AH)) ifa ();
    sobel_window_gen_if #(.WIDTH_P(8), .LINE_WIDTH_P(BW),  .FRAME_HEIGHT_P(BH)) ifb ();

    sobel_window_gen #(.WIDTH_P(8), .LINE_WIDTH_P(AW_), .FRAME_HEIGHT_P(AH)) dut_a (
        .clk_i(clk), .rst_i(rst_a), .bus(ifa));
    sobel_window_gen #(.WIDTH_P(8), .LINE_WIDTH_P(BW), .FRAME_HEIGHT_P(BH)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .bus(ifb));

    int     n_cmp = 0, n_err = 0;
    exp_t   qa [$];
    exp_t   qb [$];
    int     acc_q [$];
    win_t   got_a [$];
    int     rx_a = 0, rx_b = 0;
    bit     lat_chk = 1'b0;

    task automatic cmp(input string nm, input logic [71:0] act, input logic [71:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: window whose bottom-right pixel is at (r,c) of a w-wide raster frame.
    function automatic exp_t mk_win(input pix_q_t f, input int w, input int r, input int c);
        exp_t e;
        e.win = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                e.win[8*(3*i+j) +: 8] = f[(r-2+i)*w + (c-2+j)];
        e.row = r - 1;
        e.col = c - 1;
        return e;
    endfunction

    function automatic win_t pack9(input int v[9]);
        win_t p = '0;
        for (int i = 0; i < 9; i++) p[8*i +: 8] = 8'(v[i]);
        return p;
    endfunction

    task automatic push_a(input pix_q_t f);
        for (int r = 2; r < AH; r++)
            for (int c = 2; c < AW_; c++) qa.push_back(mk_win(f, AW_, r, c));
    endtask

    task automatic push_b(input pix_q_t f);
        for (int r = 2; r < BH; r++)
            for (int c = 2; c < BW; c++) qb.push_back(mk_win(f, BW, r, c));
    endtask

    function automatic pix_q_t ramp(input int base, input int n);
        pix_q_t f;
        for (int i = 0; i < n; i++) f.push_back(pixel_t'(base + i));
        return f;
    endfunction

    function automatic pix_q_t rand_frame(input int n);
        pix_q_t f;
        for (int i = 0; i < n; i++) f.push_back(pixel_t'($urandom_range(255)));
        return f;
    endfunction

    task automatic drive_a(input pixel_t px, input int r, input int c, input int gap);
        bit acc = 1'b0;
        while ($urandom_range(99) < gap) begin
            ifa.valid_i = 1'b0;
            @(posedge clk); #1;
        end
        ifa.data_i  = px;
        ifa.valid_i = 1'b1;
        for (int n = 0; n < 300 && !acc; n++) begin
            @(negedge clk);
            acc = ifa.ready_o;
            if (acc && r >= 2 && c >= 2) acc_q.push_back(cyc);
            @(posedge clk); #1;
        end
        cmp("accept_a", acc, 1);
    endtask

    task automatic drive_b(input pixel_t px, input int gap);
        bit acc = 1'b0;
        while ($urandom_range(99) < gap) begin
            ifb.valid_i = 1'b0;
            @(posedge clk); #1;
        end
        ifb.data_i  = px;
        ifb.valid_i = 1'b1;
        for (int n = 0; n < 300 && !acc; n++) begin
            @(negedge clk);
            acc = ifb.ready_o;
            @(posedge clk); #1;
        end
        cmp("accept_b", acc, 1);
    endtask

    task automatic send_a(input pix_q_t f, input int gap);
        for (int i = 0; i < f.size(); i++) drive_a(f[i], (i / AW_) % AH, i % AW_, gap);
        ifa.valid_i = 1'b0;
    endtask

    task automatic send_b(input pix_q_t f, input int gap);
        for (int i = 0; i < f.size(); i++) drive_b(f[i], gap);
        ifb.valid_i = 1'b0;
    endtask

    task automatic drain_a(input string nm);
        for (int n = 0; n < 400 && qa.size() > 0; n++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        cmp(nm, qa.size(), 0);
    endtask

    task automatic drain_b(input string nm);
        for (int n = 0; n < 400 && qb.size() > 0; n++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        cmp(nm, qb.size(), 0);
    endtask

    // Monitor A: scoreboard, hold stability, ready_o during stall, latency.
    bit   hold_a = 1'b0;
    win_t hold_win_a;
    always @(negedge clk) begin
        exp_t e;
        int   t;
        if (rst_a) begin
            hold_a = 1'b0;
        end else begin
            if (hold_a) begin
                cmp("hold_valid_a", ifa.valid_o, 1);
                cmp("hold_window_a", ifa.window_o, hold_win_a);
            end
            if (ifa.valid_o && !hold_a && acc_q.size() > 0) begin
                t = acc_q.pop_front();
                if (lat_chk) cmp("latency_a", cyc - t, 2);
            end
            if (ifa.valid_o && !ifa.ready_i) cmp("stall_ready_o_a", ifa.ready_o, 0);
            if (ifa.valid_o && ifa.ready_i) begin
                cmp("exp_avail_a", qa.size() > 0, 1);
                if (qa.size() > 0) begin
                    e = qa.pop_front();
                    cmp("window_a", ifa.window_o, e.win);
`ifdef SOBEL_WINDOW_COORD_EN
                    cmp("row_a", ifa.row_o, e.row);
                    cmp("col_a", ifa.col_o, e.col);
`endif
                    got_a.push_back(ifa.window_o);
                end
                rx_a++;
            end
            hold_a     = ifa.valid_o && !ifa.ready_i;
            hold_win_a = ifa.window_o;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_b && ifb.valid_o && ifb.ready_i) begin
            cmp("exp_avail_b", qb.size() > 0, 1);
            if (qb.size() > 0) begin
                e = qb.pop_front();
                cmp("window_b", ifb.window_o, e.win);
`ifdef SOBEL_WINDOW_COORD_EN
                cmp("row_b", ifb.row_o, e.row);
                cmp("col_b", ifb.col_o, e.col);
`endif
            end
            rx_b++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        pix_q_t f0, f1, f2;
        int     base;
        int     v_first[9], v_last[9], v_f2[9];
        bit     done_a;
        v_first = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        v_last  = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
        v_f2    = '{100, 101, 102, 104, 105, 106, 108, 109, 110};

        ifa.valid_i = 1'b0; ifa.data_i = '0; ifa.ready_i = 1'b1;
        ifb.valid_i = 1'b0; ifb.data_i = '0; ifb.ready_i = 1'b1;
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp("reset_ready_o_a", ifa.ready_o, 0);
        cmp("reset_valid_o_a", ifa.valid_o, 0);
        cmp("reset_window_a", ifa.window_o, 0);
        cmp("reset_ready_o_b", ifb.ready_o, 0);
        cmp("reset_valid_o_b", ifb.valid_o, 0);
        @(posedge clk); #1;
        rst_a = 1'b0; rst_b = 1'b0;

        fork
            begin : path_a
                f0 = ramp(0, 16);
                // Back-to-back stream, ready_i high.
                lat_chk = 1'b1; got_a.delete(); base = rx_a;
                push_a(f0); send_a(f0, 0); drain_a("drain_t1");
                cmp("t1_count", rx_a - base, 4);
                if (got_a.size() == 4) begin
                    cmp("t1_first", got_a[0], pack9(v_first));
                    cmp("t1_last", got_a[3], pack9(v_last));
                end

                // Five-cycle stall on the second window.
                lat_chk = 1'b0; got_a.delete(); base = rx_a;
                push_a(f0);
                fork
                    send_a(f0, 0);
                    begin
                        for (int n = 0; n < 500 && rx_a < base + 1; n++) @(negedge clk);
                        @(posedge clk); #1; ifa.ready_i = 1'b0;
                        repeat (5) @(posedge clk);
                        #1; ifa.ready_i = 1'b1;
                    end
                join
                drain_a("drain_t2");
                cmp("t2_count", rx_a - base, 4);

                // Two frames back to back.
                lat_chk = 1'b1; got_a.delete(); base = rx_a;
                f1 = ramp(100, 16);
                f2 = {f0, f1};
                push_a(f0); push_a(f1); send_a(f2, 0); drain_a("drain_t3");
                cmp("t3_count", rx_a - base, 8);
                if (got_a.size() == 8) cmp("t3_frame2_first", got_a[4], pack9(v_f2));

                // Reset after pixel 9; stale partial frame must not emit.
                base = rx_a;
                for (int i = 0; i < 10; i++) drive_a(f0[i], i / AW_, i % AW_, 0);
                ifa.valid_i = 1'b0;
                rst_a = 1'b1;
                @(negedge clk);
                cmp("rst_ready_o_a", ifa.ready_o, 0);
                @(posedge clk); #1;
                rst_a = 1'b0;
                acc_q.delete();
                repeat (5) @(posedge clk);
                #1;
                cmp("rst_no_window", rx_a - base, 0);
                cmp("rst_valid_o", ifa.valid_o, 0);
                got_a.delete();
                push_a(f0); send_a(f0, 0); drain_a("drain_t4");
                cmp("t4_count", rx_a - base, 4);
                if (got_a.size() == 4) begin
                    cmp("t4_first", got_a[0], pack9(v_first));
                    cmp("t4_last", got_a[3], pack9(v_last));
                end

                // Random data, random gaps and random ready_i over two frames.
                lat_chk = 1'b0; base = rx_a; done_a = 1'b0;
                f1 = rand_frame(16); f2 = rand_frame(16);
                push_a(f1); push_a(f2);
                fork
                    begin send_a({f1, f2}, 50); done_a = 1'b1; end
                    begin
                        while (!done_a) begin
                            @(posedge clk); #1;
                            ifa.ready_i = 1'($urandom_range(1));
                        end
                        ifa.ready_i = 1'b1;
                    end
                join
                drain_a("drain_t5");
                cmp("t5_count", rx_a - base, 8);
            end

            begin : path_b
                pix_q_t g1, g2;
                int     bb;
                bit     done_b;
                // 6x5 frame with 50% valid gaps.
                bb = rx_b;
                g1 = rand_frame(BW * BH);
                push_b(g1); send_b(g1, 50); drain_b("drain_b1");
                cmp("b1_count", rx_b - bb, 12);

                // Two more frames with random backpressure as well.
                bb = rx_b; done_b = 1'b0;
                g1 = rand_frame(BW * BH); g2 = rand_frame(BW * BH);
                push_b(g1); push_b(g2);
                fork
                    begin send_b({g1, g2}, 50); done_b = 1'b1; end
                    begin
                        while (!done_b) begin
                            @(posedge clk); #1;
                            ifb.ready_i = 1'($urandom_range(1));
                        end
                        ifb.ready_i = 1'b1;
                    end
                join
                drain_b("drain_b2");
                cmp("b2_count", rx_b - bb, 24);
            end
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Streaming 3x3 window generator for the Sobel datapath. It accepts raster-order pixels over a valid/ready handshake and buffers the two previous lines in two synchronous line RAMs. For every interior pixel position it emits the full 3x3 neighbourhood to the downstream gradient stage. Border windows are not produced.

## Interface
- WIDTH_P, 8, bits per pixel
- LINE_WIDTH_P, 640, pixels per line (>= 3)
- FRAME_HEIGHT_P, 480, lines per frame (>= 3)
- clk_i  in  1  clock; all logic on the rising edge
- rst_i  in  1  reset; synchronous, active-high
- data_i  in  WIDTH_P  input pixel
- valid_i  in  1  data_i is valid
- ready_o  out  1  block accepts data_i this cycle
- window_o  out  9*WIDTH_P  3x3 window; element (r,c) is at bits [WIDTH_P*(3r+c) +: WIDTH_P]
  - r=0 is the oldest line; c=0 is the oldest column
- valid_o  out  1  window_o is valid
- ready_i  in  1  downstream accepts window_o

## Operation
- Acceptance: a pixel is accepted when valid_i && ready_o.
- ready_o = !rst_i && (!valid_o || ready_i).
- col counter (0..LINE_WIDTH_P-1) and row counter (0..FRAME_HEIGHT_P-1) tag each accepted pixel.
  - After the last column, col goes to 0 and row increments.
  - After the last pixel of the frame, both counters go to 0. Priming restarts, and no window spans two frames.
- Line RAMs: two RAMs, each LINE_WIDTH_P x WIDTH_P, with 1-cycle read latency and read-before-write at the same address.
  - The roles are prev1 (row-1) and prev2 (row-2). A sel bit chooses which physical RAM plays each role.
- On acceptance at column c:
  - Read both RAMs at address c.
  - Write data_i into the prev2 RAM at address c in the same cycle. Read priority returns the old data.
  - At the end of each line, sel toggles: the RAM just written becomes prev1 and the old prev1 becomes prev2.
- Stage s1, one cycle after acceptance, holds:
  - s1_valid
  - the registered pixel
  - its row/col tags
  - the RAM outputs, which are the prev2 (top) and prev1 (mid) values of column c
- Window shift: when s1_valid && (!valid_o || ready_i):
  - Window columns shift left. New column c=2 = {prev2, prev1, pixel}.
  - valid_o <= (s1 row >= 2) && (s1 col >= 2). The window center is (row-1, col-1).
  - s1_valid clears unless a new pixel is accepted in the same cycle.
- Non-producing shifts (row < 2 or col < 2) still update window_o, but drive valid_o low once any prior window is consumed.
- Stall: while valid_o && !ready_i:
  - ready_o is 0 and no acceptance occurs.
  - s1, the RAM outputs and window_o hold; the RAMs are not read.
- Throughput is one window per cycle in steady state.
- Windows per frame = (FRAME_HEIGHT_P-2)*(LINE_WIDTH_P-2).

## Timing
- Latency: a pixel accepted in cycle T completes a window with valid_o high in cycle T+2.
- Reset values:
  - valid_o 0, window_o 0, s1_valid 0, counters 0, sel 0
  - ready_o 0 while rst_i is high
  - RAM contents are not cleared (don't-care, because priming restarts).
- Reset mid-frame discards any pending s1 data and window. The next accepted pixel is row 0, col 0.
- valid_i is allowed to drop mid-line. Counters and the window advance only on accepted pixels.
- valid_o && !ready_i: window_o is stable until consumed (standard AXI-style hold).

## Configuration
- SOBEL_WINDOW_COORD_EN defined:
  - Adds outputs row_o [$clog2(FRAME_HEIGHT_P)] and col_o [$clog2(LINE_WIDTH_P)], giving the window-center coordinates.
  - They are registered with window_o, reset to 0, and valid with valid_o.
- Not defined: the ports and the coordinate registers are absent; behaviour is otherwise identical.

## Structure
- sobel_pkg holds:
  - WIN_DIM = 3
  - window element index constants (TL..BR)
  - typedef pixel_t
  - a function win_idx(r,c) returning 3r+c
- Sub-module: sync_ram_block, instantiated twice with WIDTH_P/LINE_WIDTH_P and no init file. Its reset is driven low-active from !rst_i.
- Top level holds the counters, sel, s1 and window registers.

## Test plan
- LINE_WIDTH_P=4, FRAME_HEIGHT_P=4, pixels 0..15 streamed back to back with ready_i=1:
  - Exactly 4 windows.
  - First window = {0,1,2,4,5,6,8,9,10}, valid_o 2 cycles after pixel 10 is accepted.
  - Last window = {5,6,7,9,10,11,13,14,15}.
- Same stream with ready_i held low for 5 cycles on the second window: window_o is stable, ready_o is 0 during the stall, the output sequence is unchanged, and nothing is lost or duplicated.
- Random valid_i gaps (50%) over a 6x5 frame: the 12 windows match the reference model.
- Two frames back to back (values 0..15 then 100..115): the second frame's first window = {100,101,102,104,105,106,108,109,110`}`, with no mixing of frames.
- rst_i asserted for 1 cycle after pixel 9: no window is emitted for the stale data; restreaming 0..15 gives the first-test result.
- With SOBEL_WINDOW_COORD_EN defined, first test: (row_o,col_o) = (1,1),(1,2),(2,1),(2,2).
